// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR
// sample feeder slice.
package fir_pkg;

  localparam int DATA_W  = 10;
  localparam int TAPS    = 16;
  localparam int FIR_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DRAIN
  } feed_state_e;

endpackage

// File: rtl/fir_sync_fifo.sv
// Registered synchronous FIFO, no fall-through;
// pointers carry one wrap bit for full/empty.
module fir_sync_fifo #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_q;
  logic [AW:0]       rd_q;
  logic              do_push;
  logic              do_pop;

  assign level_o = wr_q - rd_q;
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign empty_o = (level_o == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Buffers host samples and streams them into the FIR,
// appending a zero tail and tagging valid FIR outputs.
module fir_sample_feeder #(
  parameter int DATA_W  = fir_pkg::DATA_W,
  parameter int DEPTH   = 16,
  parameter int TAPS    = fir_pkg::TAPS,
  parameter int FIR_LAT = fir_pkg::FIR_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    start,
  input  logic                    flush,
  output logic [DATA_W-1:0]       fir_din,
  output logic                    fir_out_valid,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             underflow_cnt
);

  import fir_pkg::*;

  localparam int CW = $clog2(TAPS);

  feed_state_e        state_q, state_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic               tag_q, tag_d;
  logic [FIR_LAT-1:0] dly_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [15:0]        uf_q, uf_d;

  logic               pop;
  logic               full;
  logic               empty;
  logic [DATA_W-1:0]  head;
  logic [CW-1:0]      cnt_dec;

  assign s_ready = !full && (state_q == IDLE || state_q == RUN);

  fir_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s_valid && s_ready),
    .data_i  (s_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  assign cnt_dec = cnt_q - CW'(1);

  always_comb begin
    state_d = state_q;
    din_d   = '0;
    tag_d   = 1'b0;
    cnt_d   = cnt_q;
    uf_d    = uf_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (!empty) begin
          pop   = 1'b1;
          din_d = head;
          tag_d = 1'b1;
        end else if (uf_q != 16'hFFFF) begin
          uf_d = uf_q + 16'd1;
        end
        if (flush) state_d = FLUSH;
      end
      FLUSH: begin
        if (!empty) begin
          pop   = 1'b1;
          din_d = head;
          tag_d = 1'b1;
        end else begin
          // This cycle's zero is the first of the TAPS-1 tail.
          tag_d   = 1'b1;
          cnt_d   = CW'(TAPS - 1);
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_dec;
        if (cnt_dec != '0) begin
          tag_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      din_q   <= '0;
      tag_q   <= 1'b0;
      dly_q   <= '0;
      cnt_q   <= '0;
      uf_q    <= '0;
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      tag_q    <= tag_d;
      dly_q[0] <= tag_q;
      for (int i = 1; i < FIR_LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
      cnt_q <= cnt_d;
      uf_q  <= uf_d;
    end
  end

  assign fir_din       = din_q;
  assign fir_out_valid = dly_q[FIR_LAT-1];
  assign underflow_cnt = uf_q;
  assign busy          = (state_q != IDLE) || tag_q || (|dly_q);

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed self-checking bench for fir_sample_feeder.
module tb_fir_sample_feeder;
  import fir_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [9:0] s_data;
  logic       start;
  logic       flush;
  logic [9:0] fir_din;
  logic       fir_out_valid;
  logic       busy;
  logic [4:0] level;
  logic [15:0] underflow_cnt;

  int tests = 0;
  int fails = 0;

  logic [9:0] dh [0:127];
  bit         vh [0:127];
  bit         bh [0:127];
  int         uh [0:127];
  int         hi = 0;

  always #5 clk = ~clk;

  fir_sample_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .start         (start),
    .flush         (flush),
    .fir_din       (fir_din),
    .fir_out_valid (fir_out_valid),
    .busy          (busy),
    .level         (level),
    .underflow_cnt (underflow_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (hi < 128) begin
      dh[hi] = fir_din;
      vh[hi] = fir_out_valid;
      bh[hi] = busy;
      uh[hi] = int'(underflow_cnt);
      hi++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int first;
    int last;
    int bad;
    bit done;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    start = 1'b0; flush = 1'b0;
    do_reset();
    chk("rst_level", 32'(level), 0);
    chk("rst_din", 32'(fir_din), 0);
    chk("rst_valid", 32'(fir_out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_uf", 32'(underflow_cnt), 0);
    chk("rst_ready", 32'(s_ready), 1);

    // prefill 3, ramp, drain
    s_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s_data = 10'(i);
      tick();
    end
    s_valid = 1'b0;
    chk("pre_level", 32'(level), 3);
    chk("pre_busy", 32'(busy), 0);
    hi = 0;
    start = 1'b1; tick(); start = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    bad = 0;
    for (int i = 1; i <= 3; i++) if (dh[i] != 10'(i)) bad++;
    for (int i = 4; i <= 18; i++) if (dh[i] != 0) bad++;
    chk("ramp_din_seq", 32'(bad), 0);
    n = 0; first = -1; last = -1;
    for (int i = 0; i < hi; i++) if (vh[i]) begin
      n++;
      if (first < 0) first = i;
      last = i;
    end
    chk("ramp_valid_cnt", 32'(n), 18);
    chk("ramp_valid_first", 32'(first), 3);
    chk("ramp_valid_last", 32'(last), 20);
    chk("ramp_uf", 32'(underflow_cnt), 0);
    chk("ramp_busy_last", 32'(bh[20]), 1);
    chk("ramp_busy_fall", 32'(bh[21]), 0);

    // underflow
    do_reset();
    hi = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    s_valid = 1'b1; s_data = 10'd7; tick(); s_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    bad = 0;
    for (int i = 1; i <= 5; i++) if (dh[i] != 0) bad++;
    chk("uf_zero_din", 32'(bad), 0);
    chk("uf_din7", 32'(dh[6]), 7);
    chk("uf_cnt", 32'(uh[6]), 5);
    n = 0;
    for (int i = 0; i <= 7; i++) if (vh[i]) n++;
    chk("uf_no_early_valid", 32'(n), 0);
    chk("uf_valid7", 32'(vh[8]), 1);

    // full backpressure
    do_reset();
    n = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_data = 10'(i);
      if (s_ready) n++;
      tick();
    end
    s_valid = 1'b0;
    chk("bp_accepts", 32'(n), 16);
    chk("bp_level", 32'(level), 16);
    chk("bp_ready", 32'(s_ready), 0);
    hi = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    bad = 0;
    for (int i = 0; i < 16; i++) if (dh[i+1] != 10'(i)) bad++;
    chk("bp_order", 32'(bad), 0);

    // flush while empty
    do_reset();
    hi = 0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    n = 0;
    for (int i = 0; i < hi; i++) if (vh[i]) n++;
    chk("fe_uf", 32'(underflow_cnt), 2);
    chk("fe_valid_cnt", 32'(n), 15);
    chk("fe_state", 32'(dut.state_q), 32'(IDLE));
    chk("fe_busy", 32'(busy), 0);

    // reset mid-stream
    do_reset();
    s_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      s_data = 10'(i);
      tick();
    end
    s_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    chk("mr_level4", 32'(level), 4);
    chk("mr_in_flush", 32'(dut.state_q), 32'(FLUSH));
    s_valid = 1'b1;
    chk("mr_ready0", 32'(s_ready), 0);
    rst = 1'b1; tick(); rst = 1'b0; s_valid = 1'b0;
    chk("mr_level", 32'(level), 0);
    chk("mr_din", 32'(fir_din), 0);
    chk("mr_valid", 32'(fir_out_valid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_state", 32'(dut.state_q), 32'(IDLE));

    // ignored controls
    do_reset();
    flush = 1'b1; tick(); flush = 1'b0;
    chk("ic_flush_idle", 32'(dut.state_q), 32'(IDLE));
    start = 1'b1; flush = 1'b1; tick(); flush = 1'b0;
    chk("ic_start_wins", 32'(dut.state_q), 32'(RUN));
    tick(); start = 1'b0;
    chk("ic_start_run", 32'(dut.state_q), 32'(RUN));
    flush = 1'b1; tick(); flush = 1'b0;
    s_valid = 1'b1; s_data = 10'd9;
    bad = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (dut.state_q == IDLE) done = 1'b1;
      else begin
        if (s_ready) bad++;
        tick();
      end
    end
    s_valid = 1'b0;
    chk("ic_drain_done", 32'(done), 1);
    chk("ic_ready_low", 32'(bad), 0);
    chk("ic_level0", 32'(level), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
